pio_tx_fifo: RTL and testbench

TX FIFO and pull controller for one PIO state machine. It sits between the system bus write port and the output shift register, and buffers 32-bit words written by the CPU/DMA. It answers explicit PULL instructions and autopull requests by driving the shift register's load strobe and data, and generates the stall that freezes the state machine when no data is available.

---
 rtl/pio_tx_fifo.sv | 174 +++++++++++++++++
 tb/tb_pio_tx_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pio_tx_fifo.sv
// pio_tx_fifo: TX word FIFO and PULL/autopull controller for one PIO state machine; optional 8-deep join mode under `PIO_TX_JOIN_EN.
// Latency: a push is poppable the next cycle (no bypass); osr_set/osr_din/stall are combinational so the load lands with the pop.
// Backpressure: pushes while full are dropped and flagged in overflow; the SM is stalled when a pull/autopull finds the FIFO empty.
module pio_tx_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             penable,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             join_mode,
    input  logic             flag_clr,
    input  logic             pull_req,
    input  logic             pull_block,
    input  logic [WIDTH-1:0] x_in,
    input  logic             out_req,
    input  logic             auto_en,
    input  logic [4:0]       pull_thresh,
    input  logic [5:0]       osr_count,
    output logic             osr_set,
    output logic [WIDTH-1:0] osr_din,
    output logic             stall,
    output logic             full,
    output logic             empty,
    output logic [3:0]       level,
    output logic             overflow,
    output logic             txstall
);

`ifdef PIO_TX_JOIN_EN
    localparam int DEPTH_MAX = 8;
`else
    localparam int DEPTH_MAX = 4;
`endif
    localparam int AW = $clog2(DEPTH_MAX);

    logic [WIDTH-1:0] r_mem [DEPTH_MAX];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [3:0]       r_level;
    logic             r_overflow;
    logic             r_txstall;

    logic             w_flush;
    logic [3:0]       w_depth;
    logic [AW-1:0]    w_last;
    logic [AW-1:0]    w_rd_nxt;
    logic [AW-1:0]    w_wr_nxt;
    logic [5:0]       w_thr;
    logic             w_ap;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_set;
    logic             w_txs_set;
    logic [WIDTH-1:0] w_head;

`ifdef PIO_TX_JOIN_EN
    logic r_join;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_join <= 1'b0;
        end else begin
            r_join <= join_mode;
        end
    end

    // Depth follows the registered join copy; the change cycle itself flushes.
    assign w_flush = (join_mode != r_join);
    assign w_depth = r_join ? 4'd8 : 4'd4;
    assign w_last  = r_join ? AW'(7) : AW'(3);
`else
    logic w_unused_join;
    assign w_unused_join = join_mode;
    assign w_flush = 1'b0;
    assign w_depth = 4'd4;
    assign w_last  = AW'(3);
`endif

    assign level    = r_level;
    assign empty    = (r_level == 4'd0);
    assign full     = (r_level == w_depth);
    assign overflow = r_overflow;
    assign txstall  = r_txstall;

    assign w_head   = r_mem[r_rd_ptr];
    assign w_rd_nxt = (r_rd_ptr == w_last) ? '0 : r_rd_ptr + 1'b1;
    assign w_wr_nxt = (r_wr_ptr == w_last) ? '0 : r_wr_ptr + 1'b1;

    // Threshold 0 encodes a full 32-bit word.
    assign w_thr = (pull_thresh == 5'd0) ? 6'd32 : {1'b0, pull_thresh};
    assign w_ap  = auto_en && (osr_count >= w_thr);

    assign w_push    = wr_en && !full;
    assign w_ovf_set = wr_en && full;

    always_comb begin
        w_pop     = 1'b0;
        w_txs_set = 1'b0;
        osr_set   = 1'b0;
        osr_din   = '0;
        stall     = 1'b0;
        if (penable) begin
            if (w_ap) begin
                if (!empty) begin
                    w_pop   = 1'b1;
                    osr_set = 1'b1;
                    osr_din = w_head;
                end else if (out_req || pull_req) begin
                    stall = 1'b1;
                end
            end else if (pull_req) begin
                if (!empty) begin
                    w_pop   = 1'b1;
                    osr_set = 1'b1;
                    osr_din = w_head;
                end else if (pull_block) begin
                    stall     = 1'b1;
                    w_txs_set = 1'b1;
                end else begin
                    osr_set = 1'b1;
                    osr_din = x_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !w_flush) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= 4'd0;
            r_overflow <= 1'b0;
            r_txstall  <= 1'b0;
        end else begin
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_level  <= 4'd0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= w_wr_nxt;
                end
                if (w_pop) begin
                    r_rd_ptr <= w_rd_nxt;
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + 4'd1;
                    2'b01:   r_level <= r_level - 4'd1;
                    default: r_level <= r_level;
                endcase
            end
            // A set in the same cycle as a clear wins.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (flag_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_txs_set) begin
                r_txstall <= 1'b1;
            end else if (flag_clr) begin
                r_txstall <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pio_tx_fifo.sv
// Directed table-driven bench for pio_tx_fifo plus hand sequences for full push/pop, async reset and join.
module tb_pio_tx_fifo;

    localparam logic [6:0] PEN = 7'h40, WR = 7'h20, CLR = 7'h10, PUL = 7'h08,
                           BLK = 7'h04, OUT = 7'h02, AUT = 7'h01;
    localparam logic [5:0] NONE = 6'h00, SET = 6'h20, STL = 6'h10, FUL = 6'h08,
                           EMP = 6'h04, OVF = 6'h02, TXS = 6'h01;

    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] wd;
        logic [31:0] xin;
        logic [4:0]  thr;
        logic [5:0]  cnt;
        logic [5:0]  ef;
        logic [31:0] edin;
        logic [3:0]  elvl;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        penable, wr_en, join_mode, flag_clr, pull_req, pull_block, out_req, auto_en;
    logic [31:0] wr_data, x_in;
    logic [4:0]  pull_thresh;
    logic [5:0]  osr_count;
    logic        osr_set, stall, full, empty, overflow, txstall;
    logic [31:0] osr_din;
    logic [3:0]  level;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl [25];

    always #5 clk = ~clk;

    pio_tx_fifo #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .penable(penable), .wr_en(wr_en), .wr_data(wr_data),
        .join_mode(join_mode), .flag_clr(flag_clr), .pull_req(pull_req), .pull_block(pull_block),
        .x_in(x_in), .out_req(out_req), .auto_en(auto_en), .pull_thresh(pull_thresh),
        .osr_count(osr_count), .osr_set(osr_set), .osr_din(osr_din), .stall(stall),
        .full(full), .empty(empty), .level(level), .overflow(overflow), .txstall(txstall)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        penable     = v.ctl[6];
        wr_en       = v.ctl[5];
        flag_clr    = v.ctl[4];
        pull_req    = v.ctl[3];
        pull_block  = v.ctl[2];
        out_req     = v.ctl[1];
        auto_en     = v.ctl[0];
        wr_data     = v.wd;
        x_in        = v.xin;
        pull_thresh = v.thr;
        osr_count   = v.cnt;
    endtask

    task automatic cyc(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, " osr_set"}, 32'(osr_set), 32'(v.ef[5]));
        chk({tag, " stall"},   32'(stall),   32'(v.ef[4]));
        chk({tag, " osr_din"}, osr_din,      v.edin);
        @(posedge clk);
        #1;
        chk({tag, " level"},    32'(level),    32'(v.elvl));
        chk({tag, " full"},     32'(full),     32'(v.ef[3]));
        chk({tag, " empty"},    32'(empty),    32'(v.ef[2]));
        chk({tag, " overflow"}, 32'(overflow), 32'(v.ef[1]));
        chk({tag, " txstall"},  32'(txstall),  32'(v.ef[0]));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " level"},    32'(level),    32'd0);
        chk({tag, " empty"},    32'(empty),    32'd1);
        chk({tag, " full"},     32'(full),     32'd0);
        chk({tag, " overflow"}, 32'(overflow), 32'd0);
        chk({tag, " txstall"},  32'(txstall),  32'd0);
        chk({tag, " osr_set"},  32'(osr_set),  32'd0);
        chk({tag, " stall"},    32'(stall),    32'd0);
        chk({tag, " osr_din"},  osr_din,       32'd0);
    endtask

    initial begin
        vec_t v;
        vec_t idle;
        idle = '{PEN, 32'h0, 32'h0, 5'd0, 6'd0, EMP, 32'h0, 4'd0};

        // ctl, wr_data, x_in, thresh, osr_count, expected flags, expected osr_din, expected level
        tbl[0]  = '{PEN|WR,          32'hA,    32'h0,    5'd0, 6'd0,  NONE,        32'h0,    4'd1};
        tbl[1]  = '{PEN|WR,          32'hB,    32'h0,    5'd0, 6'd0,  NONE,        32'h0,    4'd2};
        tbl[2]  = '{PEN|WR,          32'hC,    32'h0,    5'd0, 6'd0,  NONE,        32'h0,    4'd3};
        tbl[3]  = '{PEN|WR,          32'hD,    32'h0,    5'd0, 6'd0,  FUL,         32'h0,    4'd4};
        tbl[4]  = '{PEN|WR,          32'hE,    32'h0,    5'd0, 6'd0,  FUL|OVF,     32'h0,    4'd4};
        tbl[5]  = '{PEN|PUL|BLK,     32'h0,    32'h0,    5'd0, 6'd0,  SET|OVF,     32'hA,    4'd3};
        tbl[6]  = '{PEN|PUL|BLK|CLR, 32'h0,    32'h0,    5'd0, 6'd0,  SET,         32'hB,    4'd2};
        tbl[7]  = '{PEN|PUL|BLK,     32'h0,    32'h0,    5'd0, 6'd0,  SET,         32'hC,    4'd1};
        tbl[8]  = '{PEN|PUL|BLK,     32'h0,    32'h0,    5'd0, 6'd0,  SET|EMP,     32'hD,    4'd0};
        tbl[9]  = '{PEN|PUL|BLK,     32'h0,    32'h0,    5'd0, 6'd0,  STL|EMP|TXS, 32'h0,    4'd0};
        tbl[10] = '{PEN|WR|PUL|BLK,  32'h1234, 32'h0,    5'd0, 6'd0,  STL|TXS,     32'h0,    4'd1};
        tbl[11] = '{PEN|PUL|BLK,     32'h0,    32'h0,    5'd0, 6'd0,  SET|EMP|TXS, 32'h1234, 4'd0};
        tbl[12] = '{PEN|CLR,         32'h0,    32'h0,    5'd0, 6'd0,  EMP,         32'h0,    4'd0};
        tbl[13] = '{PEN|PUL,         32'h0,    32'hDEAD, 5'd0, 6'd0,  SET|EMP,     32'hDEAD, 4'd0};
        tbl[14] = '{PUL|BLK,         32'h0,    32'h0,    5'd0, 6'd0,  EMP,         32'h0,    4'd0};
        tbl[15] = '{PEN|WR,          32'h55,   32'h0,    5'd0, 6'd0,  NONE,        32'h0,    4'd1};
        tbl[16] = '{PEN|AUT,         32'h0,    32'hBEEF, 5'd8, 6'd7,  NONE,        32'h0,    4'd1};
        tbl[17] = '{PEN|AUT,         32'h0,    32'h0,    5'd8, 6'd8,  SET|EMP,     32'h55,   4'd0};
        tbl[18] = '{PEN|WR,          32'h66,   32'h0,    5'd0, 6'd0,  NONE,        32'h0,    4'd1};
        tbl[19] = '{PEN|AUT,         32'h0,    32'h0,    5'd0, 6'd31, NONE,        32'h0,    4'd1};
        tbl[20] = '{PEN|AUT,         32'h0,    32'h0,    5'd0, 6'd32, SET|EMP,     32'h66,   4'd0};
        tbl[21] = '{PEN|AUT|OUT,     32'h0,    32'h0,    5'd8, 6'd8,  STL|EMP,     32'h0,    4'd0};
        tbl[22] = '{PEN|AUT,         32'h0,    32'h0,    5'd8, 6'd8,  EMP,         32'h0,    4'd0};
        tbl[23] = '{WR|AUT,          32'h77,   32'h0,    5'd0, 6'd32, NONE,        32'h0,    4'd1};
        tbl[24] = '{PEN|AUT|PUL|BLK, 32'h0,    32'h0,    5'd0, 6'd40, SET|EMP,     32'h77,   4'd0};

        join_mode = 1'b0;
        drive(idle);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_state("reset");

        for (int i = 0; i < 25; i++) begin
            cyc(tbl[i], $sformatf("row%0d", i));
        end

        // Fill, then push and pop together while full.
        for (int k = 1; k <= 4; k++) begin
            v = '{PEN|WR, 32'(k), 32'h0, 5'd0, 6'd0, (k == 4) ? FUL : NONE, 32'h0, 4'(k)};
            cyc(v, $sformatf("fill%0d", k));
        end
        v = '{PEN|WR|PUL|BLK, 32'h5, 32'h0, 5'd0, 6'd0, SET|OVF, 32'h1, 4'd3};
        cyc(v, "pushpop_full");
        v = '{PEN|PUL|BLK, 32'h0, 32'h0, 5'd0, 6'd0, SET|OVF, 32'h2, 4'd2};
        cyc(v, "drain2");

        // Asynchronous reset mid-stream, checked before any clock edge.
        @(negedge clk);
        drive(idle);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("async_reset");
        @(negedge clk);
        reset = 1'b0;

`ifdef PIO_TX_JOIN_EN
        join_mode = 1'b1;
        cyc(idle, "join_flush0");
        for (int k = 1; k <= 8; k++) begin
            v = '{PEN|WR, 32'(k + 16), 32'h0, 5'd0, 6'd0, (k == 8) ? FUL : NONE, 32'h0, 4'(k)};
            cyc(v, $sformatf("join_fill%0d", k));
        end
        join_mode = 1'b0;
        cyc(idle, "join_drop");
`else
        join_mode = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            v = '{PEN|WR, 32'(k + 16), 32'h0, 5'd0, 6'd0,
                  (k == 5) ? (FUL|OVF) : ((k == 4) ? FUL : NONE), 32'h0, 4'((k > 4) ? 4 : k)};
            cyc(v, $sformatf("nojoin_fill%0d", k));
        end
        v = '{PEN|PUL, 32'h0, 32'h0, 5'd0, 6'd0, SET|OVF, 32'd17, 4'd3};
        cyc(v, "nojoin_pop");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
